// File: rtl/count_stream_monitor_pkg.sv
// ----------------------------------------------------------------------------
// count_mon_pkg
// Shared types and constants for the count stream monitor:
//   - state_t   : tracking FSM states (IDLE, TRACK, ERROR)
//   - SEG_HEX   : hex digit to 7-segment pattern table, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK : all segments off
//   - DP_TIMER_W: width of the decimal-point stretch timer (holds 1..15)
//   - hex7()    : table lookup helper
// ----------------------------------------------------------------------------
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int DP_TIMER_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high segments, {g,f,e,d,c,b,a}; lower-case b and d shapes for 0xB/0xD.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/count_stream_monitor_hex_to_seg7.sv
// ----------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex digit to 7-segment decoder. The parent registers
// the result, so this block carries no state.
// Ports:
//   nibble  in  4  hex digit to display
//   seg     out 7  segment pattern {g,f,e,d,c,b,a}, active-high
// ----------------------------------------------------------------------------
module hex_to_seg7
  import count_mon_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the current digit.
  always_comb begin
    seg = SEG_BLANK;
    seg = hex7(nibble);
  end

endmodule

// File: rtl/count_stream_monitor.sv
// ----------------------------------------------------------------------------
// count_stream_monitor
// Watches the count stream of an upstream free-running counter. Each sampled
// value must either repeat the previous one or step by +1 modulo 2^WIDTH.
// The first illegal step raises a sticky error and captures the bad value.
// Wrap-arounds (all-ones -> zero) are counted in a saturating counter and
// stretched onto the decimal point for DP_HOLD cycles. The low nibble of
// every sample is shown on a registered hex 7-segment display.
//
// Parameters:
//   WIDTH   width of count_in (>= 4; the display shows count_in[3:0])
//   WRAP_W  width of the saturating wrap counter
//   DP_HOLD decimal-point stretch length in cycles, 1..15
// Ports:
//   clk        in  1       clock, rising edge
//   rst        in  1       synchronous reset, active-high
//   count_in   in  WIDTH   value from the upstream counter
//   sample_en  in  1       count_in valid this cycle
//   clear_err  in  1       drop the error and resynchronise
//   seg        out 7       registered segment drive {g,f,e,d,c,b,a}
//   dp         out 1       registered decimal point, stretched after a wrap
//   wrap_cnt   out WRAP_W  saturating count of observed wraps
//   err        out 1       sticky step-error flag
//   err_value  out WIDTH   count_in value that caused the error
// ----------------------------------------------------------------------------
module count_stream_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int WRAP_W  = 8,
  parameter int DP_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              sample_en,
  input  logic              clear_err,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [WIDTH-1:0]  err_value
);

  localparam logic [WIDTH-1:0]      CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      CNT_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WRAP_W-1:0]     WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0]     WRAP_MAX  = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0]     WRAP_ZERO = {WRAP_W{1'b0}};
  localparam logic [DP_TIMER_W-1:0] TMR_ZERO  = {DP_TIMER_W{1'b0}};
  localparam logic [DP_TIMER_W-1:0] TMR_ONE   = {{(DP_TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [DP_TIMER_W-1:0] TMR_LOAD  = DP_TIMER_W'(DP_HOLD);

  // State and datapath registers
  state_t                state_q,     state_d;
  logic [WIDTH-1:0]      prev_q,      prev_d;
  logic [6:0]            seg_q,       seg_d;
  logic                  dp_q,        dp_d;
  logic [DP_TIMER_W-1:0] dp_timer_q,  dp_timer_d;
  logic [WRAP_W-1:0]     wrap_cnt_q,  wrap_cnt_d;
  logic                  err_q,       err_d;
  logic [WIDTH-1:0]      err_value_q, err_value_d;

  logic [WIDTH-1:0]      exp_next;
  logic                  wrap_hit;
  logic [6:0]            hex_seg;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (count_in[3:0]),
    .seg    (hex_seg)
  );

  // Expected next value of a legal step; wraps naturally at WIDTH bits.
  assign exp_next = prev_q + CNT_ONE;

  // Next-state, tracking check, wrap counting and display/dp timing.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    seg_d       = seg_q;
    wrap_cnt_d  = wrap_cnt_q;
    err_d       = err_q;
    err_value_d = err_value_q;
    wrap_hit    = 1'b0;

    // Stretch timer free-runs down to zero regardless of sampling.
    if (dp_timer_q != TMR_ZERO) begin
      dp_timer_d = dp_timer_q - TMR_ONE;
    end else begin
      dp_timer_d = TMR_ZERO;
    end

    if (sample_en) begin
      seg_d = hex_seg;
      case (state_q)
        IDLE: begin
          // First sample after reset/clear only establishes the reference.
          prev_d  = count_in;
          state_d = TRACK;
        end
        TRACK: begin
          if (count_in == prev_q) begin
            prev_d = prev_q;
          end else if (count_in == exp_next) begin
            prev_d   = count_in;
            wrap_hit = (prev_q == CNT_ONES);
          end else begin
            // Keep prev at the last good value so the capture is the bad one.
            err_d       = 1'b1;
            err_value_d = count_in;
            state_d     = ERROR;
          end
        end
        ERROR: begin
          prev_d = count_in;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (wrap_hit) begin
      // A wrap inside an active stretch restarts it.
      dp_timer_d = TMR_LOAD;
      if (wrap_cnt_q != WRAP_MAX) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
      end else begin
        wrap_cnt_d = WRAP_MAX;
      end
    end else begin
      wrap_cnt_d = wrap_cnt_d;
    end

    // Clear has priority over an error detected in the same cycle.
    if (clear_err) begin
      err_d       = 1'b0;
      err_value_d = CNT_ZERO;
      state_d     = IDLE;
    end else begin
      err_d       = err_d;
    end

    dp_d = (dp_timer_d != TMR_ZERO);
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= CNT_ZERO;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b0;
      dp_timer_q  <= TMR_ZERO;
      wrap_cnt_q  <= WRAP_ZERO;
      err_q       <= 1'b0;
      err_value_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dp_timer_q  <= dp_timer_d;
      wrap_cnt_q  <= wrap_cnt_d;
      err_q       <= err_d;
      err_value_q <= err_value_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign err       = err_q;
  assign err_value = err_value_q;

endmodule

// File: tb/tb_count_stream_monitor.sv
// ----------------------------------------------------------------------------
// tb_count_stream_monitor
// Directed stimulus with hand-computed expectations. The driver pushes the
// expected outputs for each clock into a queue; an independent monitor pops
// and compares on every falling edge.
// ----------------------------------------------------------------------------
module tb_count_stream_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       sample_en;
  logic       clear_err;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [3:0] err_value;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] wrap;
    logic       err;
    logic [3:0] ev;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] hexs [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  count_stream_monitor #(
    .WIDTH   (4),
    .WRAP_W  (8),
    .DP_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .sample_en (sample_en),
    .clear_err (clear_err),
    .seg       (seg),
    .dp        (dp),
    .wrap_cnt  (wrap_cnt),
    .err       (err),
    .err_value (err_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk({mon_e.name, " seg"},       32'(seg),       32'(mon_e.seg));
      chk({mon_e.name, " dp"},        32'(dp),        32'(mon_e.dp));
      chk({mon_e.name, " wrap_cnt"},  32'(wrap_cnt),  32'(mon_e.wrap));
      chk({mon_e.name, " err"},       32'(err),       32'(mon_e.err));
      chk({mon_e.name, " err_value"}, 32'(err_value), 32'(mon_e.ev));
    end
  end

  // One clock of stimulus plus the outputs expected after its rising edge.
  task automatic step(input logic en, input logic [3:0] v, input logic clr, input logic rs,
                      input logic [6:0] s, input logic d, input logic [7:0] w,
                      input logic e, input logic [3:0] ev, input string nm);
    exp_t x;
    sample_en = en;
    count_in  = v;
    clear_err = clr;
    rst       = rs;
    x.seg = s; x.dp = d; x.wrap = w; x.err = e; x.ev = ev; x.name = nm;
    @(posedge clk);
    #1;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_w;
    logic [3:0] v;
    rst       = 1'b1;
    sample_en = 1'b0;
    count_in  = 4'd0;
    clear_err = 1'b0;
    @(negedge clk);

    step(1'b0, 4'd0, 1'b0, 1'b1, 7'h00, 1'b0, 8'd0, 1'b0, 4'd0, "reset");

    // Count up from 0; display lags the sample by one cycle.
    step(1'b1, 4'd0, 1'b0, 1'b0, 7'h3F, 1'b0, 8'd0, 1'b0, 4'd0, "up0");
    step(1'b1, 4'd1, 1'b0, 1'b0, 7'h06, 1'b0, 8'd0, 1'b0, 4'd0, "up1");
    step(1'b1, 4'd2, 1'b0, 1'b0, 7'h5B, 1'b0, 8'd0, 1'b0, 4'd0, "up2");
    step(1'b1, 4'd3, 1'b0, 1'b0, 7'h4F, 1'b0, 8'd0, 1'b0, 4'd0, "up3");
    // No sample: a bogus value must be ignored entirely.
    step(1'b0, 4'd9, 1'b0, 1'b0, 7'h4F, 1'b0, 8'd0, 1'b0, 4'd0, "no_sample");
    for (int i = 4; i < 16; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0, hexs[i], 1'b0, 8'd0, 1'b0, 4'd0, "up_to_15");
    end

    // Wrap 15 -> 0: dp high for four cycles.
    step(1'b1, 4'd0, 1'b0, 1'b0, 7'h3F, 1'b1, 8'd1, 1'b0, 4'd0, "wrap0");
    step(1'b1, 4'd1, 1'b0, 1'b0, 7'h06, 1'b1, 8'd1, 1'b0, 4'd0, "dp_c2");
    step(1'b1, 4'd2, 1'b0, 1'b0, 7'h5B, 1'b1, 8'd1, 1'b0, 4'd0, "dp_c3");
    step(1'b1, 4'd3, 1'b0, 1'b0, 7'h4F, 1'b1, 8'd1, 1'b0, 4'd0, "dp_c4");
    step(1'b1, 4'd4, 1'b0, 1'b0, 7'h66, 1'b0, 8'd1, 1'b0, 4'd0, "dp_end");

    // Holds are legal; 6 -> 9 is not.
    step(1'b1, 4'd5, 1'b0, 1'b0, 7'h6D, 1'b0, 8'd1, 1'b0, 4'd0, "s5");
    step(1'b1, 4'd5, 1'b0, 1'b0, 7'h6D, 1'b0, 8'd1, 1'b0, 4'd0, "hold5");
    step(1'b1, 4'd6, 1'b0, 1'b0, 7'h7D, 1'b0, 8'd1, 1'b0, 4'd0, "s6");
    step(1'b1, 4'd6, 1'b0, 1'b0, 7'h7D, 1'b0, 8'd1, 1'b0, 4'd0, "hold6");
    step(1'b1, 4'd9, 1'b0, 1'b0, 7'h6F, 1'b0, 8'd1, 1'b1, 4'd9, "bad9");
    // Sticky through 20 legal samples, including a 15 -> 0 that must not count.
    for (int k = 1; k <= 20; k++) begin
      v = 4'((9 + k) % 16);
      step(1'b1, v, 1'b0, 1'b0, hexs[v], 1'b0, 8'd1, 1'b1, 4'd9, "err_sticky");
    end

    // Clear beats a simultaneous mismatch; the next sample is unchecked.
    step(1'b1, 4'd3,  1'b1, 1'b0, 7'h4F, 1'b0, 8'd1, 1'b0, 4'd0,  "clear_wins");
    step(1'b1, 4'd7,  1'b0, 1'b0, 7'h07, 1'b0, 8'd1, 1'b0, 4'd0,  "after_clear");
    step(1'b1, 4'd8,  1'b0, 1'b0, 7'h7F, 1'b0, 8'd1, 1'b0, 4'd0,  "legal8");
    step(1'b1, 4'd10, 1'b0, 1'b0, 7'h77, 1'b0, 8'd1, 1'b1, 4'd10, "bad10");
    step(1'b0, 4'd0,  1'b1, 1'b0, 7'h77, 1'b0, 8'd1, 1'b0, 4'd0,  "clear_idle");
    step(1'b1, 4'd0,  1'b0, 1'b0, 7'h3F, 1'b0, 8'd1, 1'b0, 4'd0,  "resync0");

    // 255 full wraps: counter climbs from 1 to 255 and then saturates.
    exp_w = 8'd1;
    for (int n = 1; n <= 255; n++) begin
      for (int i = 1; i < 16; i++) begin
        step(1'b1, 4'(i), 1'b0, 1'b0, hexs[i], (n > 1) && (i <= 3), exp_w, 1'b0, 4'd0, "wrap_loop");
      end
      if (exp_w != 8'd255) exp_w = exp_w + 8'd1;
      step(1'b1, 4'd0, 1'b0, 1'b0, 7'h3F, 1'b1, exp_w, 1'b0, 4'd0, "wrap_edge");
    end

    // Error during the dp stretch, then reset mid-stretch.
    step(1'b1, 4'd1, 1'b0, 1'b0, 7'h06, 1'b1, 8'd255, 1'b0, 4'd0, "sat_s1");
    step(1'b1, 4'd5, 1'b0, 1'b0, 7'h6D, 1'b1, 8'd255, 1'b1, 4'd5, "sat_bad5");
    step(1'b1, 4'd2, 1'b0, 1'b1, 7'h00, 1'b0, 8'd0,   1'b0, 4'd0, "reset_mid");
    step(1'b1, 4'd9, 1'b0, 1'b0, 7'h6F, 1'b0, 8'd0,   1'b0, 4'd0, "post_reset_any");
    step(1'b1, 4'd10, 1'b0, 1'b0, 7'h77, 1'b0, 8'd0,  1'b0, 4'd0, "post_reset_step");

    sample_en = 1'b0;
    clear_err = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/count_stream_monitor.md
Name: count_stream_monitor

Overview:
- Downstream consumer of the tt_um_kvosic_counter 4-bit count output (uo_out[3:0]).
- Samples the count stream and checks that it steps by exactly +1 modulo 2^WIDTH or holds.
- Counts wrap-arounds and drives a registered hex 7-segment display, with a stretched decimal-point pulse on each wrap.
- Flags the first illegal step as a sticky error and captures the offending value.

Parameters:
- WIDTH, 4, width of the monitored count; display decodes count_in[3:0].
- WRAP_W, 8, width of the saturating wrap counter.
- DP_HOLD, 4, cycles the dp output stays high after a wrap; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- count_in  in  WIDTH  count value from the upstream counter.
- sample_en  in  1  count_in is valid this cycle; no action when low.
- clear_err  in  1  one-cycle request: drop error and resynchronise.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
- dp  out  1  decimal point, high DP_HOLD cycles after each wrap.
- wrap_cnt  out  WRAP_W  number of wraps observed, saturating.
- err  out  1  sticky step-error flag.
- err_value  out  WIDTH  count_in value that caused the error.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at a rising edge), overrides all other inputs:
  - state=IDLE, prev=0;
  - seg=7'h00 (blank), dp=0, dp timer=0;
  - wrap_cnt=0, err=0, err_value=0.
- States: IDLE, TRACK, ERROR. With sample_en=0, state, prev and outputs hold; the dp timer still decrements.
- IDLE, sample_en=1:
  - prev<=count_in; no check;
  - next state TRACK.
- TRACK, sample_en=1, with exp = prev+1 mod 2^WIDTH:
  - count_in==prev: hold, legal; no change.
  - count_in==exp: prev<=count_in.
    - If prev was all-ones and count_in is 0: wrap_cnt<=wrap_cnt+1, saturating at all-ones; dp timer<=DP_HOLD.
  - Any other value: err<=1, err_value<=count_in, next state ERROR; prev is not updated.
- ERROR:
  - no checking; wrap_cnt frozen;
  - prev<=count_in on each sample;
  - err and err_value held.
- Display updates in every state while sample_en=1.
- clear_err=1 (any state):
  - err<=0, err_value<=0, next state IDLE; the first sample after clear is not checked.
  - If a mismatch occurs in the same cycle, clear wins: no error is recorded.
  - wrap_cnt is not cleared.
- Display and dp timing:
  - seg <= hex7(count_in[3:0]) one cycle after any sample (1-cycle latency).
  - dp = (dp timer != 0); it rises the cycle after the wrapping sample.
  - The timer decrements each cycle; a new wrap while the timer is non-zero reloads it to DP_HOLD.
- Hex encoding, {g..a}:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Reset mid-operation: every register returns to reset values on that edge, including an in-progress dp stretch and the sticky error.

Decomposition:
- Package count_mon_pkg:
  - state enum (IDLE, TRACK, ERROR);
  - SEG_HEX[16] constant table;
  - SEG_BLANK=7'h00.
- Sub-module hex_to_seg7:
  - purely combinational 4-bit to 7-bit lookup from SEG_HEX;
  - instantiated once, output registered in the parent.

Test Plan:
- Reset, then samples 0,1,2,3: seg after each = 3F,06,5B,4F (1-cycle lag); err=0; wrap_cnt=0.
- Samples 14,15,0,1: wrap_cnt=1; dp high for exactly 4 cycles starting the cycle after sample 0; err=0.
- Samples 5,5,6 (hold), then 6,9: no error on the hold; on 9, err=1 and err_value=9; err stays 1 through 20 further legal samples.
- With err=1, assert clear_err alongside mismatching sample 3: err=0; next sample 7 is accepted unchecked; then 8 is legal and 10 sets err with err_value=10.
- Force wrap_cnt to 255 via 255 full wraps, then one more wrap: wrap_cnt stays 255; dp still pulses.
- Assert rst during a dp stretch with err=1: next cycle seg=00, dp=0, wrap_cnt=0, err=0; first following sample of any value gives no error.
